// File: rtl/pipe_ff_pkg.sv
// Shared pipeline defines: datapath bus widths and the stall-bus index map.
// Pipeline register blocks size their pipe_ff fields from these widths.
// They wire stall_cur/stall_next as stall[k]/stall[k+1] using the indices below.
package pipe_ff_pkg;

  // Datapath widths
  localparam int RegWidth           = 32;  // general-purpose register width
  localparam int RegNumLog2         = 5;   // register-file address width
  localparam int InstAddrWidth      = 32;  // instruction address width
  localparam int EXC_TYPE_BUS_WIDTH = 32;  // exception-type bus width

  // Stall bus: one bit per stage, stage k feeds the register between k and k+1.
  localparam int STALL_BUS_WIDTH = 6;
  localparam int STALL_PC        = 0;
  localparam int STALL_IF        = 1;
  localparam int STALL_ID        = 2;
  localparam int STALL_EX        = 3;
  localparam int STALL_MEM       = 4;
  localparam int STALL_WB        = 5;

endpackage

// File: rtl/pipe_ff.sv
// pipe_ff: one field of a pipeline register between two stages.
// Latency: one clk from d to q on a load; no combinational d->q path.
// Backpressure: holds while both stages stall, inserts a RST_VAL bubble when
//   only the feeding stage stalls, and flush loads RST_VAL over any stall.
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-high reset, forces q to RST_VAL
//   flush      - synchronous flush (exception/eret), loads RST_VAL
//   stall_cur  - stall of the feeding stage (stall[k])
//   stall_next - stall of the consuming stage (stall[k+1])
//   d          - data from the upstream stage
//   q          - registered data to the downstream stage
module pipe_ff
  import pipe_ff_pkg::*;
#(
  parameter int               WIDTH   = RegWidth,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             stall_cur,
  input  logic             stall_next,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] reg_d;
  logic [WIDTH-1:0] reg_q;

  // Bubble: the feeding stage is stalled but the consumer moves on, so the
  // consumer must see an empty slot rather than a duplicate of the old value.
  // stall_cur=0 with stall_next=1 cannot occur in a well-formed stall vector;
  // it simply falls into the load branch.
  always_comb begin
    reg_d = reg_q;
    if (flush) begin
      reg_d = RST_VAL;
    end else if (stall_cur && !stall_next) begin
      reg_d = RST_VAL;
    end else if (!stall_cur) begin
      reg_d = d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_q <= RST_VAL;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign q = reg_q;

endmodule

// File: tb/tb_pipe_ff.sv
// Directed bench for pipe_ff: reset, load, hold, bubble, flush priority,
// illegal-stall load, and narrow / nonzero-RST_VAL instances.
module tb_pipe_ff;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        stall_cur;
  logic        stall_next;
  logic [31:0] d32;
  logic [31:0] q32;
  logic [0:0]  q1;
  logic [4:0]  q5;
  logic [7:0]  q8;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pipe_ff #(32) u_w32 (
    .clk(clk), .reset(reset), .flush(flush), .stall_cur(stall_cur),
    .stall_next(stall_next), .d(d32), .q(q32)
  );

  pipe_ff #(.WIDTH(1)) u_w1 (
    .clk(clk), .reset(reset), .flush(flush), .stall_cur(stall_cur),
    .stall_next(stall_next), .d(d32[0:0]), .q(q1)
  );

  pipe_ff #(.WIDTH(5)) u_w5 (
    .clk(clk), .reset(reset), .flush(flush), .stall_cur(stall_cur),
    .stall_next(stall_next), .d(d32[4:0]), .q(q5)
  );

  pipe_ff #(.WIDTH(8), .RST_VAL(8'hA5)) u_w8 (
    .clk(clk), .reset(reset), .flush(flush), .stall_cur(stall_cur),
    .stall_next(stall_next), .d(d32[7:0]), .q(q8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    flush      = 1'b0;
    stall_cur  = 1'b0;
    stall_next = 1'b0;
    d32        = 32'h0;
    #2;
    check("rst_q32", q32, 32'h0);
    check("rst_q1", {31'b0, q1}, 32'h0);
    check("rst_q5", {27'b0, q5}, 32'h0);
    check("rst_q8_rstval", {24'b0, q8}, 32'h0000_00A5);

    // Reset held across an edge with data present: q stays at RST_VAL.
    d32 = 32'hCAFE_F00D;
    edge1();
    check("rst_hold_edge", q32, 32'h0);

    reset = 1'b0;
    d32   = 32'hDEAD_BEEF;
    edge1();
    check("load_deadbeef", q32, 32'hDEAD_BEEF);

    // Asynchronous reset between edges, during a stall and a flush.
    #3;
    stall_cur  = 1'b1;
    stall_next = 1'b1;
    flush      = 1'b1;
    reset      = 1'b1;
    #1;
    check("async_rst_now", q32, 32'h0);
    d32 = 32'h1111_2222;
    flush = 1'b0;
    stall_cur = 1'b0;
    stall_next = 1'b0;
    edge1();
    check("async_rst_held", q32, 32'h0);
    check("async_rst_q8", {24'b0, q8}, 32'h0000_00A5);
    reset = 1'b0;

    // Load
    d32 = 32'h1234_5678;
    edge1();
    check("load_12345678", q32, 32'h1234_5678);
    check("load_q8", {24'b0, q8}, 32'h0000_0078);

    // Hold for three edges
    stall_cur  = 1'b1;
    stall_next = 1'b1;
    d32        = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      edge1();
      check($sformatf("hold_%0d", i), q32, 32'h1234_5678);
    end
    check("hold_q8", {24'b0, q8}, 32'h0000_0078);

    // Bubble
    stall_next = 1'b0;
    d32        = 32'hAAAA_5555;
    edge1();
    check("bubble", q32, 32'h0);
    check("bubble_q8_rstval", {24'b0, q8}, 32'h0000_00A5);

    // Illegal stall combo behaves as a load
    stall_cur  = 1'b0;
    stall_next = 1'b1;
    d32        = 32'h0BAD_F00D;
    edge1();
    check("illegal_combo_load", q32, 32'h0BAD_F00D);

    // Flush wins over every stall combination
    for (int c = 0; c < 4; c++) begin
      logic [1:0] sc;
      sc         = c[1:0];
      flush      = 1'b0;
      stall_cur  = 1'b0;
      stall_next = 1'b0;
      d32        = 32'h1234_5678;
      edge1();
      check($sformatf("preflush_load_%0d", c), q32, 32'h1234_5678);
      flush      = 1'b1;
      stall_cur  = sc[1];
      stall_next = sc[0];
      d32        = 32'h0000_0055;
      edge1();
      check($sformatf("flush_sc%0d_q32", c), q32, 32'h0);
      check($sformatf("flush_sc%0d_q8", c), {24'b0, q8}, 32'h0000_00A5);
    end
    flush      = 1'b0;
    stall_cur  = 1'b0;
    stall_next = 1'b0;

    // Narrow widths: load all-ones, then async reset
    d32 = 32'hFFFF_FFFF;
    edge1();
    check("w1_ones", {31'b0, q1}, 32'h1);
    check("w5_ones", {27'b0, q5}, 32'h1F);
    check("w8_ones", {24'b0, q8}, 32'hFF);
    #2;
    reset = 1'b1;
    #1;
    check("w1_rst", {31'b0, q1}, 32'h0);
    check("w5_rst", {27'b0, q5}, 32'h0);
    check("w8_rst", {24'b0, q8}, 32'h0000_00A5);
    check("w32_rst", q32, 32'h0);

    // Resume at the first edge after reset falls
    @(negedge clk);
    reset = 1'b0;
    d32   = 32'h0000_0013;
    edge1();
    check("resume_q32", q32, 32'h0000_0013);
    check("resume_q5", {27'b0, q5}, 32'h0000_0013);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
